// File: rtl/boreal_uart_resp_tx.sv
// Host-bound response transmitter: queues {cmd, addr, data} requests and sends each as a
// 9-byte UART 8N1 frame AA CMD AH AL D3 D2 D1 D0 CRC, with tx falling one clock after acceptance.
module boreal_uart_resp_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_data,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int          BAUD_DIV  = CLK_FREQ / BAUD_RATE;
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [PW:0] CNT_FULL  = (PW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [7:0]  cmd;
    logic [9:0]  addr;
    logic [31:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  req_t        mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_n;
  logic          push, pop;

  state_t      state, state_n;
  logic [15:0] baud_cnt, baud_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [3:0]  byte_idx, byte_idx_n;
  req_t        cur, cur_n;
  logic        tx_n, busy_n, ready_n;
  logic [15:0] frames_n;
  logic [7:0]  cur_byte, crc;
  logic        last;

  assign push = req_valid && req_ready;
  assign pop  = (state == IDLE) && (count != '0);
  assign last = (baud_cnt == 16'd0);

  // Request fields are captured here at push time, so later req_* changes are harmless.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cmd: req_cmd, addr: req_addr, data: req_data};
  end

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + 1'b1;
    else if (!push && pop) count_n = count - 1'b1;
  end

  assign crc = cur.cmd ^ {6'b0, cur.addr[9:8]} ^ cur.addr[7:0] ^
               cur.data[31:24] ^ cur.data[23:16] ^ cur.data[15:8] ^ cur.data[7:0];

  always_comb begin
    case (byte_idx)
      4'd0:    cur_byte = 8'hAA;
      4'd1:    cur_byte = cur.cmd;
      4'd2:    cur_byte = {6'b0, cur.addr[9:8]};
      4'd3:    cur_byte = cur.addr[7:0];
      4'd4:    cur_byte = cur.data[31:24];
      4'd5:    cur_byte = cur.data[23:16];
      4'd6:    cur_byte = cur.data[15:8];
      4'd7:    cur_byte = cur.data[7:0];
      default: cur_byte = crc;
    endcase
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    cur_n      = cur;
    tx_n       = tx;
    frames_n   = frames_sent;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (count != '0) begin
          cur_n      = mem[rd_ptr];
          byte_idx_n = 4'd0;
          baud_cnt_n = BAUD_LAST;
          state_n    = START;
          tx_n       = 1'b0;
        end
      end
      START: begin
        if (last) begin
          state_n    = DATA;
          bit_idx_n  = 3'd0;
          baud_cnt_n = BAUD_LAST;
          tx_n       = cur_byte[0];
        end else begin
          baud_cnt_n = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        if (last) begin
          baud_cnt_n = BAUD_LAST;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = cur_byte[bit_idx + 3'd1];
          end
        end else begin
          baud_cnt_n = baud_cnt - 16'd1;
        end
      end
      default: begin
        if (last) begin
          if (byte_idx < 4'd8) begin
            byte_idx_n = byte_idx + 4'd1;
            baud_cnt_n = BAUD_LAST;
            state_n    = START;
            tx_n       = 1'b0;
          end else begin
            frames_n = frames_sent + 16'd1;
            state_n  = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt - 16'd1;
        end
      end
    endcase
  end

  // Ready looks at the post-update count, so a full FIFO never sees an extra push.
  assign ready_n = (count_n < CNT_FULL);
  assign busy_n  = (state_n != IDLE) || (count_n != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      baud_cnt    <= 16'd0;
      bit_idx     <= 3'd0;
      byte_idx    <= 4'd0;
      cur         <= '0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      req_ready   <= 1'b0;
      frames_sent <= 16'd0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state       <= state_n;
      baud_cnt    <= baud_cnt_n;
      bit_idx     <= bit_idx_n;
      byte_idx    <= byte_idx_n;
      cur         <= cur_n;
      tx          <= tx_n;
      busy        <= busy_n;
      req_ready   <= ready_n;
      frames_sent <= frames_n;
      count       <= count_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_boreal_uart_resp_tx.sv
// Bench for boreal_uart_resp_tx: table of frames plus hand sequences; a UART decoder on tx
// pops expected bytes pushed when each request is accepted.
module tb_boreal_uart_resp_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [9:0]  req_addr;
  logic [31:0] req_data;
  logic        tx;
  logic        busy;
  logic [15:0] frames_sent;

  boreal_uart_resp_tx #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .tx         (tx),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  cmd;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [7:0]  crc;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] exp_q [$];
  int         fstart [$];
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] crc_of(input logic [7:0] c, input logic [9:0] a, input logic [31:0] d);
    return c ^ {6'b0, a[9:8]} ^ a[7:0] ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  task automatic push_exp(input logic [7:0] c, input logic [9:0] a, input logic [31:0] d,
                          input logic [7:0] k);
    exp_q.push_back(8'hAA);
    exp_q.push_back(c);
    exp_q.push_back({6'b0, a[9:8]});
    exp_q.push_back(a[7:0]);
    exp_q.push_back(d[31:24]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(k);
  endtask

  // Returns at the negedge right after the accepting edge; c_acc+1 is that edge's index.
  task automatic push_req(input logic [7:0] c, input logic [9:0] a, input logic [31:0] d,
                          input logic [7:0] k, output int c_acc);
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = c;
    req_addr  = a;
    req_data  = d;
    for (int g = 0; g < 3000 && !req_ready; g++) @(negedge clk);
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: req_ready stuck at 0");
    end else begin
      push_exp(c, a, d, k);
    end
    c_acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_cmd   = ~c;
    req_data  = ~d;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc && busy; i++) @(negedge clk);
    check("idle_reached", busy, 1'b0);
  endtask

  // UART decoder: samples every negedge, mid-bit at offset 5 of each 10-clock bit.
  bit         mon_act = 1'b0;
  int         mon_cnt = 0;
  int         mon_bidx = 0;
  logic [7:0] mon_byte;
  always @(negedge clk) begin
    if (rst) begin
      mon_act  = 1'b0;
      mon_bidx = 0;
      exp_q.delete();
    end else if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
        if (mon_bidx == 0) fstart.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 5) check("start_bit", tx, 1'b0);
      if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5)
        mon_byte[(mon_cnt - 15) / 10] = tx;
      if (mon_cnt == 95) begin
        check("stop_bit", tx, 1'b1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte: got %02h want no byte", mon_byte);
        end else begin
          check("frame_byte", mon_byte, exp_q.pop_front());
        end
        mon_act  = 1'b0;
        mon_bidx = (mon_bidx + 1) % 9;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c;
    int         fs0;
    int         acc;
    int         acc_at_low;
    int         errs;
    logic [7:0] aa;
    logic       expb;
    logic [7:0] bc;
    logic [9:0] ba;
    logic [31:0] bd;

    vecs[0] = '{cmd: 8'h81, addr: 10'h2A5, data: 32'hDEADBEEF, crc: 8'h04};
    vecs[1] = '{cmd: 8'h00, addr: 10'h3FF, data: 32'h00000000, crc: 8'hFC};
    vecs[2] = '{cmd: 8'h5A, addr: 10'h001, data: 32'h12345678, crc: 8'h53};
    vecs[3] = '{cmd: 8'hFF, addr: 10'h100, data: 32'hFFFFFFFF, crc: 8'hFE};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_cmd   = 8'h0;
    req_addr  = 10'h0;
    req_data  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_ready", req_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frames", frames_sent, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);

    for (int v = 0; v < 4; v++) begin
      fs0 = int'(frames_sent);
      push_req(vecs[v].cmd, vecs[v].addr, vecs[v].data, vecs[v].crc, c);
      check("lat_pre_fall", tx, 1'b1);
      check("busy_on_accept", busy, 1'b1);
      @(negedge clk);
      check("lat_fall", tx, 1'b0);
      wait_idle(2000);
      check("frame_len", cyc - c, 902);
      check("frames_sent_inc", frames_sent, 16'(fs0 + 1));
      check("queue_drained", exp_q.size(), 0);
    end

    // 0xAA start/data/stop pattern, clock by clock.
    aa = 8'hAA;
    errs = 0;
    push_req(8'h81, 10'h2A5, 32'hDEADBEEF, 8'h04, c);
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (j < 10)      expb = 1'b0;
      else if (j < 90) expb = aa[(j - 10) / 10];
      else             expb = 1'b1;
      if (tx !== expb) errs++;
    end
    check("bit_timing_errs", errs, 0);
    wait_idle(2000);

    // Back-pressure: valid held for 20 clocks with distinct payloads.
    fstart.delete();
    fs0 = int'(frames_sent);
    acc = 0;
    acc_at_low = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bc = 8'h10 + 8'(i);
      ba = 10'(i * 37 + 3);
      bd = 32'hA5C30000 | 32'(i * 4099);
      req_valid = 1'b1;
      req_cmd   = bc;
      req_addr  = ba;
      req_data  = bd;
      if (req_ready) begin
        push_exp(bc, ba, bd, crc_of(bc, ba, bd));
        acc++;
      end else if (acc_at_low < 0) begin
        acc_at_low = acc;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_accepted", acc, 5);
    check("bp_ready_fell_after", acc_at_low, 5);
    check("bp_ready_low", req_ready, 1'b0);
    wait_idle(6000);
    check("bp_frames_sent", frames_sent, 16'(fs0 + 5));
    check("bp_frame_count", fstart.size(), 5);
    for (int i = 1; i < 5 && i < fstart.size(); i++)
      check("bp_frame_gap", fstart[i] - fstart[i-1], 901);
    check("bp_queue_drained", exp_q.size(), 0);

    // Reset during the start bit of byte 4 with a second frame still queued.
    push_req(vecs[2].cmd, vecs[2].addr, vecs[2].data, vecs[2].crc, c);
    push_req(vecs[3].cmd, vecs[3].addr, vecs[3].data, vecs[3].crc, fs0);
    for (int g = 0; g < 1000 && cyc < c + 2 + 404; g++) @(negedge clk);
    check("pre_rst_tx_low", tx, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_frames", frames_sent, 16'h0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", req_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_tx", tx, 1'b1);
    push_req(vecs[0].cmd, vecs[0].addr, vecs[0].data, vecs[0].crc, c);
    wait_idle(2000);
    check("post_rst_frames", frames_sent, 16'h1);
    check("post_rst_queue", exp_q.size(), 0);
    repeat (50) @(negedge clk);
    check("no_stale_busy", busy, 1'b0);
    check("no_stale_frames", frames_sent, 16'h1);

    // Counter wrap via backdoor preload.
    force dut.frames_sent = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.frames_sent;
    @(negedge clk);
    check("wrap_preload", frames_sent, 16'hFFFF);
    push_req(vecs[1].cmd, vecs[1].addr, vecs[1].data, vecs[1].crc, c);
    wait_idle(2000);
    check("wrap_frames", frames_sent, 16'h0000);
    check("wrap_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
